// File: rtl/qoi_line_scheduler.sv
// Line sequencer for the RGB444 QOI encoder: clears it per line, gates H_PIXELS pixels, reports byte count.
// Optional QOI_SCHED_STATS_EN adds a per-frame byte accumulator on output frame_bytes.
module qoi_line_scheduler #(
  parameter int unsigned H_PIXELS     = 640,
  parameter int unsigned V_LINES      = 480,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned IND_W        = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [11:0]      pix_data,
  output logic             pix_ready,
  output logic             enc_rst_n,
  output logic             enc_en,
  output logic [11:0]      enc_rgb,
  input  logic [IND_W-1:0] enc_ind,
  output logic             line_valid,
  input  logic             line_ready,
  output logic [IND_W-1:0] line_bytes,
  output logic [8:0]       line_idx,
  output logic             line_ovf,
  output logic             frame_done,
  output logic             sync_err,
  output logic             busy
`ifdef QOI_SCHED_STATS_EN
  ,
  output logic [31:0]      frame_bytes
`endif
);

  localparam int unsigned CNT_W = $clog2(H_PIXELS + 1);
  localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic [IND_W-1:0]   prev_ind_q, prev_ind_d;
  logic [IND_W-1:0]   bytes_q, bytes_d;
  logic [8:0]         idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic               sync_err_q, sync_err_d;
`ifdef QOI_SCHED_STATS_EN
  logic [31:0]        fbytes_q, fbytes_d;
`endif

  // State and datapath registers; synchronous reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pix_cnt_q  <= '0;
      drain_q    <= '0;
      prev_ind_q <= '0;
      bytes_q    <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef QOI_SCHED_STATS_EN
      fbytes_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      drain_q    <= drain_d;
      prev_ind_q <= prev_ind_d;
      bytes_q    <= bytes_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      sync_err_q <= sync_err_d;
`ifdef QOI_SCHED_STATS_EN
      fbytes_q   <= fbytes_d;
`endif
    end
  end

  // Next-state and handshake logic
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    drain_d    = drain_q;
    prev_ind_d = prev_ind_q;
    bytes_d    = bytes_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    sync_err_d = sync_err_q;
`ifdef QOI_SCHED_STATS_EN
    fbytes_d   = fbytes_q;
`endif
    pix_ready  = 1'b0;
    enc_en     = 1'b0;
    frame_done = 1'b0;

    // Index wrap detection runs while the encoder may still be emitting bytes
    if (state_q == S_RUN || state_q == S_DRAIN) begin
      prev_ind_d = enc_ind;
      if (enc_ind < prev_ind_q) ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d    = S_CLEAR;
          idx_d      = '0;
          sync_err_d = 1'b0;
`ifdef QOI_SCHED_STATS_EN
          fbytes_d   = '0;
`endif
        end
      end
      S_CLEAR: begin
        state_d    = S_RUN;
        pix_cnt_d  = '0;
        ovf_d      = 1'b0;
        prev_ind_d = '0;
      end
      S_RUN: begin
        pix_ready = 1'b1;
        enc_en    = pix_valid;
        if (pix_valid) begin
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
          if (pix_cnt_q == CNT_W'(H_PIXELS - 1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DRN_W'(1);
        if (drain_q == DRN_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_REPORT;
          bytes_d = enc_ind;
        end
      end
      S_REPORT: begin
        if (line_ready) begin
`ifdef QOI_SCHED_STATS_EN
          fbytes_d = fbytes_q + 32'(bytes_q) + (ovf_q ? (32'd1 << IND_W) : 32'd0);
`endif
          if (idx_q == 9'(V_LINES - 1)) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = S_CLEAR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_start && state_q != S_IDLE) sync_err_d = 1'b1;
  end

  assign enc_rst_n  = rst_n & (state_q != S_CLEAR);
  assign enc_rgb    = (state_q == S_RUN) ? pix_data : 12'h000;
  assign line_valid = (state_q == S_REPORT);
  assign line_bytes = bytes_q;
  assign line_idx   = idx_q;
  assign line_ovf   = ovf_q;
  assign sync_err   = sync_err_q;
  assign busy       = (state_q != S_IDLE);
`ifdef QOI_SCHED_STATS_EN
  assign frame_bytes = fbytes_q;
`endif

endmodule
